flush_scheduler: RTL and testbench

- Frame-flush controller for the 160x120 6-bit-colour VGA framebuffer path.
- Sweeps the shared flush_x/flush_y scan coordinates that all sprite/title/glyph renderers sample.
- Resolves their colour/enable outputs by fixed priority and drives the VGA adapter write port, one pixel per clock.
- Sits between the game FSM (start/done) and the vga_adapter plot interface.

---
 rtl/flush_scheduler_if.sv | 27 ++
 rtl/flush_scheduler.sv | 176 +++++++++++++++++
 tb/tb_flush_scheduler.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flush_scheduler_if.sv
// -----------------------------------------------------------------------------
// flush_scheduler_if
//   Write port between the frame-flush controller and the VGA adapter.
//
//   Handshake: vga_plot is a valid-only strobe. The adapter has no ready and
//   accepts every beat, so one pixel is written on each cycle where vga_plot=1.
//   vga_x/vga_y/vga_colour are qualified by vga_plot and hold their last value
//   while it is low.
//
//   Signals:
//     vga_x      [7:0]  write column
//     vga_y      [6:0]  write row
//     vga_colour [5:0]  write colour
//     vga_plot          write strobe
//   Modports:
//     master  - the flush controller (drives the port)
//     slave   - the VGA adapter (observes the port)
// -----------------------------------------------------------------------------
interface flush_scheduler_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [5:0] vga_colour;
  logic       vga_plot;

  modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
  modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);
endinterface

// File: rtl/flush_scheduler.sv
// -----------------------------------------------------------------------------
// flush_scheduler
//   Frame-flush controller for the 160x120, 6-bit-colour framebuffer path.
//   On start it sweeps flush_x/flush_y across the whole screen in raster order,
//   resolves the renderer layers by fixed priority (layer 0 highest, BG_COLOUR
//   when nothing is enabled) and writes one pixel per clock to the VGA adapter
//   through a single output register stage.
//
//   Optional build macro: FLUSH_AUTO_RESTART_EN
//     defined   - after DONE the scan restarts at (0,0) without a new start;
//                 the DONE cycle itself scans pixel (0,0), so frames repeat
//                 every SCREEN_W*SCREEN_H+1 cycles and frame_busy only drops
//                 during DONE.
//     undefined - DONE returns to IDLE; every frame needs its own start.
//
//   Ports:
//     clk           system clock
//     reset         asynchronous reset, active-high
//     start         request one frame flush (sampled only in IDLE)
//     hold          freezes the scan while in SCAN
//     layer_colour  layer i colour in bits [6i+5:6i]
//     layer_enable  layer i covers the current flush pixel
//     flush_x/y     current scan coordinate, fed to all renderers
//     vga           write port to the adapter (master modport)
//     frame_busy    high in SCAN and DRAIN
//     frame_done    one-cycle pulse at end of frame (DONE state)
//     state_dbg     current FSM state: 0 IDLE, 1 SCAN, 2 DRAIN, 3 DONE
// -----------------------------------------------------------------------------
module flush_scheduler #(
  parameter int          SCREEN_W   = 160,
  parameter int          SCREEN_H   = 120,
  parameter int          NUM_LAYERS = 4,
  parameter logic [5:0]  BG_COLOUR  = 6'b000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hold,
  input  logic [6*NUM_LAYERS-1:0]   layer_colour,
  input  logic [NUM_LAYERS-1:0]     layer_enable,
  output logic [7:0]                flush_x,
  output logic [7:0]                flush_y,
  flush_scheduler_if.master         vga,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic [1:0]                state_dbg
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] x_q, y_q;
  logic       last_px;
  logic       step;        // current pixel is emitted and the scan advances
  logic [5:0] pix_colour;

  assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign flush_x   = x_q;
  assign flush_y   = y_q;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SCAN;
      SCAN:  if (step && last_px) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE: begin
`ifdef FLUSH_AUTO_RESTART_EN
        // DONE already scanned (0,0); a 1x1 screen is finished right here.
        state_nxt = last_px ? DRAIN : SCAN;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    step       = 1'b0;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      SCAN: begin
        step       = !hold;
        frame_busy = 1'b1;
      end
      DRAIN: frame_busy = 1'b1;
      DONE: begin
        frame_done = 1'b1;
`ifdef FLUSH_AUTO_RESTART_EN
        // hold is ignored outside SCAN, so the restart pixel always goes out.
        step = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan counters: raster order, back to (0,0) after the last pixel so IDLE
  // and the next frame both start from the origin.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= 8'd0;
      y_q <= 8'd0;
    end else if (step) begin
      if (last_px) begin
        x_q <= 8'd0;
        y_q <= 8'd0;
      end else if (x_q == X_LAST) begin
        x_q <= 8'd0;
        y_q <= y_q + 8'd1;
      end else begin
        x_q <= x_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority resolve: walk from the lowest priority up so the lowest enabled
  // index is the last assignment and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_colour = BG_COLOUR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_enable[i]) pix_colour = layer_colour[6*i +: 6];
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one register, latency 1. Coordinate/colour only load on a
  // plotted pixel so they hold while vga_plot is low. vga_y keeps the low
  // 7 bits only; the row count never exceeds 128.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga.vga_x      <= 8'd0;
      vga.vga_y      <= 7'd0;
      vga.vga_colour <= 6'd0;
      vga.vga_plot   <= 1'b0;
    end else begin
      vga.vga_plot <= step;
      if (step) begin
        vga.vga_x      <= x_q;
        vga.vga_y      <= y_q[6:0];
        vga.vga_colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_flush_scheduler.sv
// -----------------------------------------------------------------------------
// tb_flush_scheduler
//   Bench for flush_scheduler at default parameters. Renderers are modelled as
//   rectangles that drive layer_enable/layer_colour from flush_x/flush_y; the
//   expected pixel stream is built from the rectangle table by a first-match
//   priority lookup and checked by a negedge scoreboard.
// -----------------------------------------------------------------------------
module tb_flush_scheduler;
  localparam int         W  = 160;
  localparam int         H  = 120;
  localparam int         NL = 4;
  localparam logic [5:0] BG = 6'b000000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic hold;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6*NL-1:0] layer_colour;
  logic [NL-1:0]   layer_enable;
  logic [7:0]      flush_x, flush_y;
  logic            frame_busy, frame_done;
  logic [1:0]      state_dbg;

  flush_scheduler_if bus();

  flush_scheduler #(
    .SCREEN_W  (W),
    .SCREEN_H  (H),
    .NUM_LAYERS(NL),
    .BG_COLOUR (BG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hold        (hold),
    .layer_colour(layer_colour),
    .layer_enable(layer_enable),
    .flush_x     (flush_x),
    .flush_y     (flush_y),
    .vga         (bus.master),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Renderer model: one rectangle per layer. Disabled layers still drive a
  // coordinate-dependent colour so the enable qualification matters.
  // ---------------------------------------------------------------------------
  bit         rects_on = 1'b0;
  int         rx0[NL], rx1[NL], ry0[NL], ry1[NL];
  logic [5:0] rcol[NL];
  logic [7:0] noise;

  always_comb begin
    layer_enable = '0;
    layer_colour = '0;
    noise        = flush_x ^ flush_y;
    for (int i = 0; i < NL; i++) begin
      if (rects_on && int'(flush_x) >= rx0[i] && int'(flush_x) <= rx1[i] &&
          int'(flush_y) >= ry0[i] && int'(flush_y) <= ry1[i]) begin
        layer_enable[i]         = 1'b1;
        layer_colour[6*i +: 6]  = rcol[i];
      end else begin
        layer_colour[6*i +: 6]  = noise[5:0] ^ 6'(i + 1);
      end
    end
  end

  function automatic logic [5:0] model_colour(int x, int y);
    if (!rects_on) return BG;
    for (int i = 0; i < NL; i++)
      if (x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i]) return rcol[i];
    return BG;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [20:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          plot_cnt;
  int          first_plot_cyc;
  int          last_plot_cyc;
  logic [5:0]  plot_mem [0:H-1][0:W-1];
  logic [20:0] sb_got, sb_want;

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({8'(x), 7'(y), model_colour(x, y)});
  endtask

  task automatic clear_obs();
    plot_cnt       = 0;
    first_plot_cyc = -1;
    last_plot_cyc  = -1;
  endtask

  always @(negedge clk) begin
    if (bus.vga_plot === 1'b1) begin
      plot_cnt++;
      if (first_plot_cyc < 0) first_plot_cyc = cyc;
      last_plot_cyc = cyc;
      sb_got = {bus.vga_x, bus.vga_y, bus.vga_colour};
      if (int'(bus.vga_x) < W && int'(bus.vga_y) < H)
        plot_mem[bus.vga_y][bus.vga_x] = bus.vga_colour;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL plot_extra: got x=%0d y=%0d c=%h, required no plot (cyc %0d)",
                 bus.vga_x, bus.vga_y, bus.vga_colour, cyc);
      end else begin
        sb_want = exp_q.pop_front();
        if (sb_got !== sb_want) begin
          bad++;
          $display("FAIL plot_data: got x=%0d y=%0d c=%h, required x=%0d y=%0d c=%h (cyc %0d)",
                   sb_got[20:13], sb_got[12:6], sb_got[5:0],
                   sb_want[20:13], sb_want[12:6], sb_want[5:0], cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic do_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (flush_x !== 8'd0 || flush_y !== 8'd0) begin
      bad++;
      $display("FAIL reset_flush: got x=%0d y=%0d, required 0 0", flush_x, flush_y);
    end
    total++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 22'd0) begin
      bad++;
      $display("FAIL reset_vga: got x=%0d y=%0d c=%h p=%b, required all 0",
               bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot);
    end
    total++;
    if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got busy=%b done=%b, required 0 0", frame_busy, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (plot_cnt !== 0 || frame_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: got plots=%0d busy=%b, required 0 0", plot_cnt, frame_busy);
    end
  endtask

  // All layers off, start pulses in mid-frame, DRAIN and DONE must be ignored.
  task automatic test_blank_frame();
    int s, c, d_cnt, d_cyc;
    rects_on = 1'b0;
    clear_obs();
    push_frame();
    do_start(s);
    total++;
    if (flush_x !== 8'd0 || flush_y !== 8'd0 || frame_busy !== 1'b1) begin
      bad++;
      $display("FAIL first_flush: got x=%0d y=%0d busy=%b, required 0 0 1", flush_x, flush_y, frame_busy);
    end
    d_cnt = 0;
    d_cyc = -1;
    for (int k = 0; k < W*H + 60; k++) begin
      @(negedge clk);
      c = cyc;
      if (frame_done === 1'b1) begin
        d_cnt++;
        d_cyc = c;
      end
      start = (c == s + W*H/2) || (c == s + W*H) || (c == s + W*H + 1);
      if (c == s + W*H) begin
        total++;
        if (frame_busy !== 1'b1 || frame_done !== 1'b0 || bus.vga_plot !== 1'b1 ||
            bus.vga_x !== 8'd159 || bus.vga_y !== 7'd119) begin
          bad++;
          $display("FAIL drain_last_plot: got busy=%b done=%b p=%b x=%0d y=%0d, required 1 0 1 159 119",
                   frame_busy, frame_done, bus.vga_plot, bus.vga_x, bus.vga_y);
        end
      end
      if (c == s + W*H + 1) begin
        total++;
        if (frame_busy !== 1'b0 || frame_done !== 1'b1) begin
          bad++;
          $display("FAIL done_status: got busy=%b done=%b, required 0 1", frame_busy, frame_done);
        end
      end
    end
    start = 1'b0;
    #1;
    total++;
    if (plot_cnt !== W*H) begin
      bad++;
      $display("FAIL blank_plot_count: got %0d, required %0d", plot_cnt, W*H);
    end
    total++;
    if (first_plot_cyc !== s + 1 || last_plot_cyc !== s + W*H) begin
      bad++;
      $display("FAIL blank_plot_window: got first=%0d last=%0d, required %0d %0d",
               first_plot_cyc, last_plot_cyc, s + 1, s + W*H);
    end
    total++;
    if (d_cnt !== 1 || d_cyc !== s + W*H + 1) begin
      bad++;
      $display("FAIL blank_done_pulse: got count=%0d at=%0d, required 1 at %0d", d_cnt, d_cyc, s + W*H + 1);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL blank_missing: got %0d pixels unplotted, required 0", exp_q.size());
    end
  endtask

  // Overlapping layers plus a 10-cycle hold at (80,10) and random short holds.
  task automatic test_priority_hold();
    int s, c, hold_left, hold_total, big_start, done_c;
    rx0[0] = 0;  rx1[0] = 7;  ry0[0] = 0; ry1[0] = 5;  rcol[0] = 6'h3F;
    rx0[2] = 3;  rx1[2] = 30; ry0[2] = 2; ry1[2] = 20; rcol[2] = 6'h0C;
    rx0[1] = $urandom_range(0, 100); rx1[1] = rx0[1] + $urandom_range(0, 59);
    ry0[1] = $urandom_range(30, 80); ry1[1] = ry0[1] + $urandom_range(0, 39);
    rcol[1] = 6'($urandom_range(0, 63));
    rx0[3] = $urandom_range(0, 80);  rx1[3] = rx0[3] + $urandom_range(0, 79);
    ry0[3] = $urandom_range(0, 60);  ry1[3] = ry0[3] + $urandom_range(0, 59);
    rcol[3] = 6'($urandom_range(1, 63));
    rects_on = 1'b1;
    clear_obs();
    push_frame();
    do_start(s);
    hold_left  = 0;
    hold_total = 0;
    big_start  = -1;
    done_c     = -1;
    for (int k = 0; k < W*H + 2000 && done_c < 0; k++) begin
      @(negedge clk);
      c = cyc;
      if (frame_done === 1'b1) done_c = c;
      if (big_start >= 0 && c > big_start && c <= big_start + 10) begin
        total++;
        if (bus.vga_plot !== 1'b0) begin
          bad++;
          $display("FAIL hold_no_plot: got plot=1 at x=%0d y=%0d, required 0", bus.vga_x, bus.vga_y);
        end
      end
      if (big_start >= 0 && (c == big_start + 11 || c == big_start + 12)) begin
        total++;
        if (bus.vga_plot !== 1'b1 || bus.vga_y !== 7'd10 ||
            int'(bus.vga_x) !== 80 + (c - big_start - 11)) begin
          bad++;
          $display("FAIL hold_resume: got p=%b x=%0d y=%0d, required 1 %0d 10",
                   bus.vga_plot, bus.vga_x, bus.vga_y, 80 + (c - big_start - 11));
        end
      end
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
        hold_total++;
      end else begin
        hold = 1'b0;
        if (big_start < 0 && flush_x == 8'd80 && flush_y == 8'd10) begin
          hold       = 1'b1;
          hold_left  = 9;
          hold_total++;
          big_start  = c;
        end else if (flush_y >= 8'd20 && flush_y < 8'd100 && $urandom_range(0, 99) == 0) begin
          hold      = 1'b1;
          hold_left = $urandom_range(0, 4);
          hold_total++;
        end
      end
    end
    hold = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (done_c !== s + W*H + 1 + hold_total) begin
      bad++;
      $display("FAIL hold_done_cycle: got %0d, required %0d (holds=%0d)", done_c, s + W*H + 1 + hold_total, hold_total);
    end
    total++;
    if (plot_cnt !== W*H || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL hold_plot_count: got %0d plots, %0d pending, required %0d and 0", plot_cnt, exp_q.size(), W*H);
    end
    total++;
    if (plot_mem[3][5] !== 6'h3F) begin
      bad++;
      $display("FAIL prio_l0_over_l2: got %h, required 3f", plot_mem[3][5]);
    end
    total++;
    if (plot_mem[3][20] !== 6'h0C) begin
      bad++;
      $display("FAIL prio_l2_only: got %h, required 0c", plot_mem[3][20]);
    end
  endtask

  // Asynchronous reset in the middle of a frame, then a clean restart.
  task automatic test_reset_mid_frame();
    int s, pc0;
    bit found;
    rx0[3] = 0; rx1[3] = W - 1; ry0[3] = 40; ry1[3] = 80;
    rcol[3] = 6'($urandom_range(1, 63));
    rects_on = 1'b1;
    clear_obs();
    push_frame();
    do_start(s);
    found = 1'b0;
    for (int k = 0; k < W*H && !found; k++) begin
      @(negedge clk);
      if (flush_x == 8'd40 && flush_y == 8'd60) found = 1'b1;
    end
    total++;
    if (!found || bus.vga_plot !== 1'b1) begin
      bad++;
      $display("FAIL reach_40_60: got found=%b plot=%b, required 1 1", found, bus.vga_plot);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (flush_x !== 8'd0 || flush_y !== 8'd0 || frame_busy !== 1'b0 || frame_done !== 1'b0 ||
        {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 22'd0) begin
      bad++;
      $display("FAIL async_reset: got fx=%0d fy=%0d busy=%b x=%0d y=%0d c=%h p=%b, required all 0",
               flush_x, flush_y, frame_busy, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pc0 = plot_cnt;
    repeat (40) @(negedge clk);
    #1;
    total++;
    if (plot_cnt !== pc0 || frame_busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_quiet: got %0d new plots busy=%b, required 0 0", plot_cnt - pc0, frame_busy);
    end
    clear_obs();
    push_frame();
    do_start(s);
    repeat (300) @(negedge clk);
    #1;
    total++;
    if (first_plot_cyc !== s + 1 || plot_cnt !== 299) begin
      bad++;
      $display("FAIL restart: got first=%0d plots=%0d, required %0d 299", first_plot_cyc, plot_cnt, s + 1);
    end
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef FLUSH_AUTO_RESTART_EN
  // One start, frames repeat on their own.
  task automatic test_auto_restart();
    int s, c, d0, d1;
    rects_on = 1'b0;
    clear_obs();
    push_frame();
    push_frame();
    push_frame();
    do_start(s);
    d0 = -1;
    d1 = -1;
    for (int k = 0; k < 2*W*H + 100; k++) begin
      @(negedge clk);
      c = cyc;
      if (frame_done === 1'b1) begin
        total++;
        if (frame_busy !== 1'b0) begin
          bad++;
          $display("FAIL auto_busy_in_done: got busy=%b, required 0", frame_busy);
        end
        if (d0 < 0) d0 = c;
        else if (d1 < 0) d1 = c;
      end
      if (d0 >= 0 && c == d0 + 1) begin
        total++;
        if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0 || frame_busy !== 1'b1) begin
          bad++;
          $display("FAIL auto_first_plot: got p=%b x=%0d y=%0d busy=%b, required 1 0 0 1",
                   bus.vga_plot, bus.vga_x, bus.vga_y, frame_busy);
        end
      end
      if (d1 >= 0 && c >= d1 + 3) break;
    end
    total++;
    if (d0 !== s + W*H + 1) begin
      bad++;
      $display("FAIL auto_first_done: got %0d, required %0d", d0, s + W*H + 1);
    end
    total++;
    if (d1 - d0 !== W*H + 1) begin
      bad++;
      $display("FAIL auto_period: got %0d, required %0d", d1 - d0, W*H + 1);
    end
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < NL; i++) begin
      rx0[i] = 0; rx1[i] = -1; ry0[i] = 0; ry1[i] = -1; rcol[i] = 6'd0;
    end
    clear_obs();
    test_reset();
`ifdef FLUSH_AUTO_RESTART_EN
    test_auto_restart();
`else
    test_blank_frame();
    test_priority_hold();
    test_reset_mid_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
